// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    // Requester indices; also used as the 1-bit grant index.
    localparam logic CORE   = 1'b0;
    localparam logic LOADER = 1'b1;

    // Legal memory latency range; the wait counter is 4 bits wide.
    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 15;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin select.
// A lone request wins outright; with both active, the requester that was
// not granted last wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    // Pick a winner from the active request bits.
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = CORE;
        if (req == 2'b11) begin
            gnt_idx = ~last_gnt;
        end else if (req[LOADER]) begin
            gnt_idx = LOADER;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: core (index 0) and loader/debug (index 1)
// share one memory port with a fixed MEM_LAT-cycle access window.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Out-of-range latencies are clamped so the 4-bit counter compare stays valid.
    localparam int LAT = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                         (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
    localparam logic [3:0] LAST_CNT = 4'(LAT - 1);

    arb_state_t        state_q, state_d;
    logic [3:0]        cnt_q;
    logic              idx_q;
    logic              we_q;
    logic              last_gnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic gnt_valid;
    logic gnt_idx;
    logic start;
    logic last_cyc;

    rr_pick2 u_pick (
        .req       (req),
        .last_gnt  (last_gnt_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign last_cyc = (state_q == ACCESS) && (cnt_q == LAST_CNT);

    // Next-state and memory/ack strobes, all decoded from the current state.
    always_comb begin
        state_d     = state_q;
        start       = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        ack         = 2'b00;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d = ACCESS;
                    start   = 1'b1;
                end
            end
            ACCESS: begin
                mem_en = 1'b1;
                mem_we = we_q;
                if (last_cyc) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ack[CORE]   = (idx_q == CORE);
                ack[LOADER] = (idx_q == LOADER);
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Holding registers, wait counter and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= 4'd0;
            idx_q      <= CORE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            last_gnt_q <= LOADER;
        end else if (start) begin
            cnt_q      <= 4'd0;
            idx_q      <= gnt_idx;
            we_q       <= we[gnt_idx];
            addr_q     <= (gnt_idx == LOADER) ? addr1 : addr0;
            wdata_q    <= (gnt_idx == LOADER) ? wdata1 : wdata0;
            last_gnt_q <= gnt_idx;
        end else if (state_q == ACCESS) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    // Read data is captured on the final access edge and held across writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (last_cyc && !we_q) begin
            rdata_q <= mem_rdata;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width in bits.
REQ-002 Parameter DATA_W, default 32, data width in bits.
REQ-003 Parameter MEM_LAT, default 2, memory access cycles; legal range 1..15.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req  input  2  per-requester access request; bit 0 is the core, bit 1 is the loader/debug port.
REQ-007 we  input  2  per-requester write enable, qualified by req.
REQ-008 addr0, addr1  input  ADDR_W each  per-requester byte address.
REQ-009 wdata0, wdata1  input  DATA_W each  per-requester write data.
REQ-010 ack  output  2  per-requester completion pulse.
REQ-011 rdata  output  DATA_W  read data, shared by both requesters.
REQ-012 mem_en, mem_we  output  1 each  memory enable and memory write strobe.
REQ-013 mem_addr  output  ADDR_W  memory address.
REQ-014 mem_wdata  output  DATA_W  memory write data.
REQ-015 mem_rdata  input  DATA_W  memory read data, valid in the last ACCESS cycle.

Function
REQ-016 FSM states: IDLE, ACCESS, DONE.
- IDLE -> ACCESS when req != 0.
- ACCESS -> DONE when the wait counter reaches MEM_LAT-1.
- DONE -> IDLE unconditionally.
REQ-017 In IDLE, a single active req bit is granted. With both bits active, the grant goes to the requester not granted last (round-robin pointer last_gnt).
REQ-018 On the IDLE->ACCESS edge, capture into holding registers:
- granted index;
- we;
- addr;
- wdata.
Update last_gnt at the same edge.
REQ-019 ACCESS lasts exactly MEM_LAT cycles. The 4-bit wait counter is cleared on entry and incremented each ACCESS cycle.
REQ-020 During ACCESS:
- mem_en=1;
- mem_we = latched we;
- mem_addr and mem_wdata come from the holding registers;
- all three are stable for the whole ACCESS period.
REQ-021 Outside ACCESS: mem_en=0, mem_we=0. mem_addr and mem_wdata hold their last value.
REQ-022 On reads, rdata is registered from mem_rdata at the last ACCESS edge and held until the next read completes. Writes leave rdata unchanged.
REQ-023 In DONE, ack[granted]=1 for exactly one cycle and the other ack bit is 0. ack is 0 in every other state.
REQ-024 Latency is fixed: req first seen in IDLE in cycle 0 -> ACCESS in cycles 1..MEM_LAT -> ack in cycle MEM_LAT+1.
REQ-025 Handshake:
- a requester holds req, we, addr and wdata stable until it sees ack;
- it deasserts req in the cycle after ack unless it issues a new request.
REQ-026 A req still high in IDLE after DONE is a new request and is arbitrated normally.
REQ-027 Input changes during ACCESS or DONE are ignored.
REQ-028 Withdrawal of req mid-access does not abort the access; ack still pulses.
REQ-029 Back-to-back contention alternates grants 0,1,0,1. Neither requester waits more than one access.
REQ-030 MEM_LAT=1 gives one ACCESS cycle; the counter compare still holds.

Reset
REQ-031 While rst is high:
- state=IDLE and wait counter=0;
- ack=0, mem_en=0, mem_we=0;
- mem_addr=0, mem_wdata=0, rdata=0;
- last_gnt=1, so the core wins the first contention.
REQ-032 Reset asserted mid-ACCESS aborts the access immediately; no ack is issued for it.
REQ-033 After rst is released, the first rising edge evaluates IDLE normally.

Structure
REQ-034 Package mem_arb_pkg holds:
- the state enum (IDLE, ACCESS, DONE);
- the requester index constants CORE=0, LOADER=1;
- the MEM_LAT range constants.
REQ-035 Sub-module rr_pick2 is the combinational two-way round-robin select: inputs req[1:0] and last_gnt; outputs gnt_valid and gnt_idx.
REQ-036 FSM, counter and holding registers live in mem_arbiter; no other sub-modules.

Verification
REQ-037 Read, MEM_LAT=2: req=01, we=00, addr0=0x40, mem_rdata=0xDEADBEEF -> mem_en high cycles 1-2 with mem_addr=0x40; ack=01 in cycle 3; rdata=0xDEADBEEF.
REQ-038 Write, loader: req=10, we=10, addr1=0x80, wdata1=0x12345678 -> mem_we=1 for 2 cycles with mem_wdata=0x12345678; ack=10 in cycle 3; rdata unchanged.
REQ-039 Contention after reset: req=11 held, each requester re-requesting after its ack -> ack order 01,10,01,10; successive acks 4 cycles apart (MEM_LAT=2).
REQ-040 Withdrawal: req=01 drops to 00 in cycle 2 of ACCESS -> access completes and ack=01 still pulses in cycle 3.
REQ-041 Reset mid-op: rst pulsed in cycle 1 of ACCESS -> all outputs 0 asynchronously, no ack; a subsequent req=11 grants the core first.
REQ-042 MEM_LAT=1 build: single read at addr0=0x4 -> one mem_en cycle; ack in cycle 2.
